// File: rtl/mem_bus_responder_if.sv
// Request/response bus between a cache-side master and the SRAM responder.
// The master drives requests and rsp_ready; the slave drives req_ready and responses.
interface mem_bus_responder_if #(
  parameter int DATA_SIZE  = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_rw;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_SIZE-1:0]   req_byteen;
  logic [8*DATA_SIZE-1:0] req_data;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [8*DATA_SIZE-1:0] rsp_data;
  logic [TAG_WIDTH-1:0]   rsp_tag;

  modport master (
    output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/mem_bus_responder.sv
// SRAM-backed memory bus slave: fixed-latency, in-order tagged responses with
// credit-based request flow control so accepted requests never stall internally.
module mem_bus_responder #(
  parameter int DATA_SIZE  = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 8,
  parameter int LATENCY    = 2,
  parameter int RSP_DEPTH  = 4,
  parameter bit WRITE_RSP  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_responder_if.slave bus
);
  localparam int DW    = 8*DATA_SIZE;
  localparam int WORDS = 1 << ADDR_WIDTH;
  localparam int CNT_W = $clog2(RSP_DEPTH+1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [DW-1:0]        mem_q [WORDS];

  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic                 req_ready;
  logic                 accept;
  logic                 in_vld;
  logic [DW-1:0]        in_data;
  logic [TAG_WIDTH-1:0] in_tag;

  logic                 push;
  logic [DW-1:0]        push_data;
  logic [TAG_WIDTH-1:0] push_tag;

  logic [DW-1:0]        fifo_data_q [RSP_DEPTH];
  logic [TAG_WIDTH-1:0] fifo_tag_q  [RSP_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic                 rsp_valid;
  logic                 rsp_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit check only looks at registered state, so ready never depends on req_valid.
  assign req_ready     = (outstanding_q < CNT_W'(RSP_DEPTH));
  assign bus.req_ready = req_ready;
  assign accept        = bus.req_valid && req_ready;

  assign in_vld  = accept && (!bus.req_rw || WRITE_RSP);
  assign in_data = bus.req_rw ? '0 : mem_q[bus.req_addr];
  assign in_tag  = bus.req_tag;

  always_ff @(posedge clk) begin
    if (accept && bus.req_rw) begin
      for (int b = 0; b < DATA_SIZE; b++) begin
        if (bus.req_byteen[b]) begin
          mem_q[bus.req_addr][8*b +: 8] <= bus.req_data[8*b +: 8];
        end
      end
    end
  end

  generate
    if (LATENCY > 1) begin : g_pipe
      logic [LATENCY-2:0]   vld_q;
      logic [DW-1:0]        data_q [LATENCY-1];
      logic [TAG_WIDTH-1:0] tag_q  [LATENCY-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= in_vld;
          for (int i = 1; i < LATENCY-1; i++) begin
            vld_q[i] <= vld_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        tag_q[0]  <= in_tag;
        for (int i = 1; i < LATENCY-1; i++) begin
          data_q[i] <= data_q[i-1];
          tag_q[i]  <= tag_q[i-1];
        end
      end

      assign push      = vld_q[LATENCY-2];
      assign push_data = data_q[LATENCY-2];
      assign push_tag  = tag_q[LATENCY-2];
    end else begin : g_nopipe
      assign push      = in_vld;
      assign push_data = in_data;
      assign push_tag  = in_tag;
    end
  endgenerate

  assign rsp_valid     = (fifo_cnt_q != '0);
  assign rsp_fire      = rsp_valid && bus.rsp_ready;
  assign bus.rsp_valid = rsp_valid;
  // Zero outside a valid response keeps the idle/reset bus value defined.
  assign bus.rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.rsp_tag   = rsp_valid ? fifo_tag_q[rd_ptr_q]  : '0;

  always_comb begin
    outstanding_d = outstanding_q;
    if (in_vld && !rsp_fire) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!in_vld && rsp_fire) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (rsp_fire) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !rsp_fire) begin
      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    end else if (!push && rsp_fire) begin
      fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_tag_q[wr_ptr_q]  <= push_tag;
    end
  end

  a_credit_bound: assert property (@(posedge clk) disable iff (reset)
    outstanding_q <= CNT_W'(RSP_DEPTH));

  a_fifo_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !rsp_fire && (fifo_cnt_q == CNT_W'(RSP_DEPTH))));

endmodule
